// File: rtl/vc_mem_pkg.sv
// vc_mem_pkg: shared definitions for the val/rdy memory interface and the
// two-port memory arbiter.
//   MEM_RW_READ / MEM_RW_WRITE : encoding of the request rw bit
//   ARB_PORT_W                 : width of an arbiter port ID
//   port_id_t, PORT0, PORT1    : port ID type and values
//   is_read()                  : true when an rw bit encodes a read
package vc_mem_pkg;

  localparam logic MEM_RW_READ  = 1'b0;
  localparam logic MEM_RW_WRITE = 1'b1;

  localparam int unsigned ARB_PORT_W = 1;

  typedef logic [ARB_PORT_W-1:0] port_id_t;

  localparam port_id_t PORT0 = port_id_t'(0);
  localparam port_id_t PORT1 = port_id_t'(1);

  function automatic logic is_read(input logic rw);
    return rw == MEM_RW_READ;
  endfunction

endpackage

// File: rtl/vc_mem_arb_tagq.sv
// vc_mem_arb_tagq: circular FIFO of port IDs, one entry per outstanding read.
//   clk, reset_n : clock, asynchronous active-low reset (queue empties)
//   push_i       : enqueue push_id_i (ignored when full)
//   push_id_i    : port ID of the read that just fired
//   pop_i        : dequeue the head entry (ignored when empty)
//   head_o       : port ID of the oldest outstanding read
//   full_o       : DEPTH entries held (registered, never depends on pop_i)
//   empty_o      : no entries held
// DEPTH must be a power of two >= 2 so the pointers wrap naturally.
module vc_mem_arb_tagq
  import vc_mem_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic     clk,
  input  logic     reset_n,
  input  logic     push_i,
  input  port_id_t push_id_i,
  input  logic     pop_i,
  output port_id_t head_o,
  output logic     full_o,
  output logic     empty_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  port_id_t      ids_q [DEPTH];
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          do_push;
  logic          do_pop;

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign head_o  = ids_q[rd_ptr_q];

  always_comb begin
    cnt_d = cnt_q;
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) ids_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) begin
        ids_q[wr_ptr_q] <= push_id_i;
        wr_ptr_q        <= wr_ptr_q + PW'(1);
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + PW'(1);
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/vc_mem_arb2.sv
// vc_mem_arb2: shares one single-port val/rdy memory between two requesters.
// Round-robin request arbitration (or fixed priority to port 0 when
// MEMARB_FIXED_PRIO_EN is defined); read responses are routed back in order
// using a queue of port IDs.
//   clk, reset_n                    : clock, asynchronous active-low reset
//   reqN_bits_rw/addr/data, reqN_val: request from port N (N = 0,1)
//   reqN_rdy                        : request N accepted when val & rdy
//   respN_bits_data, respN_val      : read response to port N, one cycle
//   memreq_bits_rw/addr/data, memreq_val, memreq_rdy : request to memory
//   memresp_bits_data, memresp_val  : read response from memory
//   err                             : sticky, response seen with no read outstanding
module vc_mem_arb2
  import vc_mem_pkg::*;
#(
  parameter int unsigned ADDR_SZ    = 8,
  parameter int unsigned DATA_SZ    = 32,
  parameter int unsigned TAGQ_DEPTH = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               req0_bits_rw,
  input  logic [ADDR_SZ-1:0] req0_bits_addr,
  input  logic [DATA_SZ-1:0] req0_bits_data,
  input  logic               req0_val,
  output logic               req0_rdy,
  input  logic               req1_bits_rw,
  input  logic [ADDR_SZ-1:0] req1_bits_addr,
  input  logic [DATA_SZ-1:0] req1_bits_data,
  input  logic               req1_val,
  output logic               req1_rdy,
  output logic [DATA_SZ-1:0] resp0_bits_data,
  output logic               resp0_val,
  output logic [DATA_SZ-1:0] resp1_bits_data,
  output logic               resp1_val,
  output logic               memreq_bits_rw,
  output logic [ADDR_SZ-1:0] memreq_bits_addr,
  output logic [DATA_SZ-1:0] memreq_bits_data,
  output logic               memreq_val,
  input  logic               memreq_rdy,
  input  logic [DATA_SZ-1:0] memresp_bits_data,
  input  logic               memresp_val,
  output logic               err
);

  port_id_t           gnt;
  logic               elig0;
  logic               elig1;
  logic               gnt_val;
  logic               gnt_rw;
  logic [ADDR_SZ-1:0] gnt_addr;
  logic [DATA_SZ-1:0] gnt_data;
  logic               ok;
  logic               fire;
  logic               lock_q;
  logic               lock_d;
  port_id_t           lock_port_q;
  logic               tq_full;
  logic               tq_empty;
  port_id_t           tq_head;
  logic               err_q;
  logic               err_d;
`ifndef MEMARB_FIXED_PRIO_EN
  port_id_t           last_grant_q;
  port_id_t           last_grant_d;
`endif

  // A read that would overflow the tag queue is not eligible, so the other
  // port (e.g. a write) can take the memory instead of waiting behind it.
  assign elig0 = req0_val & ~(is_read(req0_bits_rw) & tq_full);
  assign elig1 = req1_val & ~(is_read(req1_bits_rw) & tq_full);

  always_comb begin
    gnt = PORT0;
    if (lock_q) begin
      gnt = lock_port_q;
    end else if (elig0 && elig1) begin
`ifdef MEMARB_FIXED_PRIO_EN
      gnt = PORT0;
`else
      gnt = (last_grant_q == PORT0) ? PORT1 : PORT0;
`endif
    end else if (elig1) begin
      gnt = PORT1;
    end else if (elig0) begin
      gnt = PORT0;
    end else if (req1_val) begin
      gnt = PORT1;
    end
  end

  always_comb begin
    gnt_val  = req0_val;
    gnt_rw   = req0_bits_rw;
    gnt_addr = req0_bits_addr;
    gnt_data = req0_bits_data;
    if (gnt == PORT1) begin
      gnt_val  = req1_val;
      gnt_rw   = req1_bits_rw;
      gnt_addr = req1_bits_addr;
      gnt_data = req1_bits_data;
    end
  end

  // Full is registered inside the tag queue, so ok never sees memresp_val.
  assign ok   = ~(is_read(gnt_rw) & tq_full);
  assign fire = memreq_val & memreq_rdy;

  // Outputs are forced low while reset_n is asserted.
  assign memreq_val       = reset_n & gnt_val & ok;
  assign memreq_bits_rw   = reset_n & gnt_rw;
  assign memreq_bits_addr = reset_n ? gnt_addr : '0;
  assign memreq_bits_data = reset_n ? gnt_data : '0;
  assign req0_rdy         = reset_n & memreq_rdy & ok & (gnt == PORT0);
  assign req1_rdy         = reset_n & memreq_rdy & ok & (gnt == PORT1);

  // Hold the grant while the memory back-pressures a presented request.
  assign lock_d = memreq_val & ~memreq_rdy;
  assign err_d  = err_q | (memresp_val & tq_empty);

  assign resp0_val       = memresp_val & ~tq_empty & (tq_head == PORT0);
  assign resp1_val       = memresp_val & ~tq_empty & (tq_head == PORT1);
  assign resp0_bits_data = reset_n ? memresp_bits_data : '0;
  assign resp1_bits_data = reset_n ? memresp_bits_data : '0;
  assign err             = err_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lock_q      <= 1'b0;
      lock_port_q <= PORT0;
      err_q       <= 1'b0;
    end else begin
      lock_q      <= lock_d;
      lock_port_q <= gnt;
      err_q       <= err_d;
    end
  end

`ifndef MEMARB_FIXED_PRIO_EN
  assign last_grant_d = fire ? gnt : last_grant_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) last_grant_q <= PORT1;
    else          last_grant_q <= last_grant_d;
  end
`endif

  vc_mem_arb_tagq #(
    .DEPTH (TAGQ_DEPTH)
  ) u_tagq (
    .clk       (clk),
    .reset_n   (reset_n),
    .push_i    (fire & is_read(gnt_rw)),
    .push_id_i (gnt),
    .pop_i     (memresp_val),
    .head_o    (tq_head),
    .full_o    (tq_full),
    .empty_o   (tq_empty)
  );

endmodule

// File: tb/tb_vc_mem_arb2.sv
// tb_vc_mem_arb2: directed bench for vc_mem_arb2 with two request sources,
// a simple in-order memory model and a response scoreboard.
module tb_vc_mem_arb2;

  localparam int unsigned AW  = 8;
  localparam int unsigned DW  = 32;
  localparam int unsigned TQD = 4;

  typedef struct {
    logic          rw;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } req_t;

  logic          clk;
  logic          reset_n;
  logic          req0_bits_rw, req1_bits_rw;
  logic [AW-1:0] req0_bits_addr, req1_bits_addr;
  logic [DW-1:0] req0_bits_data, req1_bits_data;
  logic          req0_val, req1_val, req0_rdy, req1_rdy;
  logic [DW-1:0] resp0_bits_data, resp1_bits_data;
  logic          resp0_val, resp1_val;
  logic          memreq_bits_rw;
  logic [AW-1:0] memreq_bits_addr;
  logic [DW-1:0] memreq_bits_data;
  logic          memreq_val, memreq_rdy;
  logic [DW-1:0] memresp_bits_data;
  logic          memresp_val;
  logic          err;

  int            errors = 0;
  int            checks = 0;
  req_t          src0[$], src1[$];
  logic [DW-1:0] exp0[$], exp1[$], pending[$];
  int            glog[$];
  logic [DW-1:0] mem [256];
  bit            src_en;
  bit            resp_hold;
  int            base;
  int            n;

  vc_mem_arb2 #(
    .ADDR_SZ    (AW),
    .DATA_SZ    (DW),
    .TAGQ_DEPTH (TQD)
  ) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .req0_bits_rw      (req0_bits_rw),
    .req0_bits_addr    (req0_bits_addr),
    .req0_bits_data    (req0_bits_data),
    .req0_val          (req0_val),
    .req0_rdy          (req0_rdy),
    .req1_bits_rw      (req1_bits_rw),
    .req1_bits_addr    (req1_bits_addr),
    .req1_bits_data    (req1_bits_data),
    .req1_val          (req1_val),
    .req1_rdy          (req1_rdy),
    .resp0_bits_data   (resp0_bits_data),
    .resp0_val         (resp0_val),
    .resp1_bits_data   (resp1_bits_data),
    .resp1_val         (resp1_val),
    .memreq_bits_rw    (memreq_bits_rw),
    .memreq_bits_addr  (memreq_bits_addr),
    .memreq_bits_data  (memreq_bits_data),
    .memreq_val        (memreq_val),
    .memreq_rdy        (memreq_rdy),
    .memresp_bits_data (memresp_bits_data),
    .memresp_val       (memresp_val),
    .err               (err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, want);
    end
  endtask

  // Queue a request; for reads d is the hand-computed expected read data.
  task automatic put(input int p, input logic rw, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_t r;
    r.rw   = rw;
    r.addr = a;
    r.data = rw ? d : '0;
    if (p == 0) begin
      src0.push_back(r);
      if (!rw) exp0.push_back(d);
    end else begin
      src1.push_back(r);
      if (!rw) exp1.push_back(d);
    end
  endtask

  task automatic run_src(input int p);
    req_t r;
    forever begin
      @(posedge clk); #1;
      if (src_en && p == 0 && src0.size() != 0) begin
        r = src0[0];
        req0_val = 1'b1; req0_bits_rw = r.rw; req0_bits_addr = r.addr; req0_bits_data = r.data;
        @(negedge clk);
        if (req0_rdy) void'(src0.pop_front());
      end else if (src_en && p == 1 && src1.size() != 0) begin
        r = src1[0];
        req1_val = 1'b1; req1_bits_rw = r.rw; req1_bits_addr = r.addr; req1_bits_data = r.data;
        @(negedge clk);
        if (req1_rdy) void'(src1.pop_front());
      end else if (p == 0) begin
        req0_val = 1'b0;
      end else begin
        req1_val = 1'b0;
      end
    end
  endtask

  initial run_src(0);
  initial run_src(1);

  // Memory response driver: one queued read per cycle unless held.
  initial begin
    memresp_val       = 1'b0;
    memresp_bits_data = '0;
    forever begin
      @(posedge clk); #1;
      if (!resp_hold && pending.size() != 0) begin
        memresp_val       = 1'b1;
        memresp_bits_data = pending.pop_front();
      end else begin
        memresp_val       = 1'b0;
        memresp_bits_data = '0;
      end
    end
  end

  // Memory acceptance, grant log and response scoreboard.
  always @(negedge clk) begin
    if (memreq_val && memreq_rdy) begin
      if (memreq_bits_rw) mem[memreq_bits_addr] = memreq_bits_data;
      else                pending.push_back(mem[memreq_bits_addr]);
    end
    if (req0_val && req0_rdy) glog.push_back(0);
    if (req1_val && req1_rdy) glog.push_back(1);
    if (resp0_val) begin
      if (exp0.size() == 0) chk("resp0_unexpected", {31'b0, resp0_val}, 32'd0);
      else                  chk("resp0_data", resp0_bits_data, exp0.pop_front());
    end
    if (resp1_val) begin
      if (exp1.size() == 0) chk("resp1_unexpected", {31'b0, resp1_val}, 32'd0);
      else                  chk("resp1_data", resp1_bits_data, exp1.pop_front());
    end
  end

  function automatic int outstanding();
    return src0.size() + src1.size() + exp0.size() + exp1.size() + pending.size();
  endfunction

  task automatic wait_all(input int max, input string name);
    int k = 0;
    while (outstanding() != 0 && k < max) begin
      @(negedge clk);
      k++;
    end
    chk(name, outstanding(), 32'd0);
  endtask

  initial begin
    reset_n = 1'b0; memreq_rdy = 1'b1; src_en = 1'b1; resp_hold = 1'b0;
    req0_val = 1'b0; req0_bits_rw = 1'b0; req0_bits_addr = '0; req0_bits_data = '0;
    req1_val = 1'b0; req1_bits_rw = 1'b0; req1_bits_addr = '0; req1_bits_data = '0;
    for (int i = 0; i < 256; i++) mem[i] = '0;

    // Reset state
    @(negedge clk);
    chk("rst_memreq_val", memreq_val, 32'd0);
    chk("rst_req0_rdy", req0_rdy, 32'd0);
    chk("rst_req1_rdy", req1_rdy, 32'd0);
    chk("rst_err", err, 32'd0);
    @(posedge clk); #2 reset_n = 1'b1;

    // Port 0 only: write then read back
    put(0, 1'b1, 8'h00, 32'haaaaaaaa);
    put(0, 1'b0, 8'h00, 32'haaaaaaaa);
    wait_all(50, "t1_drain");

    // Both ports stream; port 0 won last, so port 1 is granted first
    src_en = 1'b0;
    base = glog.size();
    for (int i = 0; i < 3; i++) begin
      put(0, 1'b1, 8'(4 * i), 32'h11110000 + 32'(4 * i));
      put(1, 1'b1, 8'(12 + 4 * i), 32'h22220000 + 32'(12 + 4 * i));
    end
    for (int i = 0; i < 3; i++) begin
      put(0, 1'b0, 8'(4 * i), 32'h11110000 + 32'(4 * i));
      put(1, 1'b0, 8'(12 + 4 * i), 32'h22220000 + 32'(12 + 4 * i));
    end
    src_en = 1'b1;
    wait_all(100, "t2_drain");
`ifndef MEMARB_FIXED_PRIO_EN
    chk("t2_ngrants", glog.size() - base, 32'd12);
    for (int i = 0; i < 12 && base + i < glog.size(); i++)
      chk($sformatf("t2_grant%0d", i), glog[base + i], (i % 2 == 0) ? 32'd1 : 32'd0);
`endif

    // Lock: port 0 presented under stall, port 1 joins; grant must not move
    @(posedge clk); #1;
    memreq_rdy = 1'b0;
    base = glog.size();
    put(0, 1'b1, 8'h40, 32'h33330040);
    n = 0;
    do begin @(negedge clk); n++; end while (!req0_val && n < 10);
    put(1, 1'b1, 8'h44, 32'h44440044);
    repeat (3) begin
      @(negedge clk);
      chk("t3_lock_addr", memreq_bits_addr, 32'h40);
      chk("t3_req1_rdy", req1_rdy, 32'd0);
    end
    @(posedge clk); #1 memreq_rdy = 1'b1;
    wait_all(50, "t3_drain");
    chk("t3_ngrants", glog.size() - base, 32'd2);
    if (glog.size() >= base + 2) begin
      chk("t3_first", glog[base], 32'd0);
      chk("t3_second", glog[base + 1], 32'd1);
    end

    // Tag queue full: 5th read waits, a write from port 1 still proceeds
    resp_hold = 1'b1;
    put(0, 1'b0, 8'h00, 32'h11110000);
    put(0, 1'b0, 8'h04, 32'h11110004);
    put(0, 1'b0, 8'h08, 32'h11110008);
    put(0, 1'b0, 8'h0c, 32'h2222000c);
    put(0, 1'b0, 8'h10, 32'h22220010);
    n = 0;
    while (src0.size() > 1 && n < 40) begin @(negedge clk); n++; end
    chk("t4_four_fired", src0.size(), 32'd1);
    repeat (3) begin
      @(negedge clk);
      chk("t4_rd5_rdy", req0_rdy, 32'd0);
      chk("t4_memreq_val", memreq_val, 32'd0);
    end
    put(1, 1'b1, 8'h48, 32'h55550048);
    n = 0;
    while (src1.size() != 0 && n < 20) begin @(negedge clk); n++; end
    chk("t4_wr_while_full", src1.size(), 32'd0);
    chk("t4_rd5_pending", src0.size(), 32'd1);
    resp_hold = 1'b0;
    wait_all(60, "t4_drain");

    // Reset with two reads outstanding; their responses become strays
    resp_hold = 1'b1;
    put(0, 1'b0, 8'h40, 32'h33330040);
    put(0, 1'b0, 8'h44, 32'h44440044);
    n = 0;
    while (src0.size() != 0 && n < 20) begin @(negedge clk); n++; end
    @(posedge clk); #2 reset_n = 1'b0;
    exp0.delete();
    put(1, 1'b1, 8'h50, 32'h66660050);
    @(negedge clk);
    @(negedge clk);
    chk("t5_rst_req1_rdy", req1_rdy, 32'd0);
    chk("t5_rst_memreq_val", memreq_val, 32'd0);
    chk("t5_rst_memreq_addr", memreq_bits_addr, 32'd0);
    chk("t5_rst_err", err, 32'd0);
    @(posedge clk); #2 reset_n = 1'b1;
    @(negedge clk);
    chk("t5_err_before_stray", err, 32'd0);
    resp_hold = 1'b0;
    wait_all(40, "t5_drain");
    repeat (2) @(negedge clk);
    chk("t5_err_sticky", err, 32'd1);

    // After reset port 0 wins the first contested grant; cross-port reads
    src_en = 1'b0;
    base = glog.size();
    put(0, 1'b1, 8'h80, 32'h77770080);
    put(1, 1'b1, 8'h84, 32'h88880084);
    put(0, 1'b0, 8'h84, 32'h88880084);
    put(1, 1'b0, 8'h80, 32'h77770080);
    src_en = 1'b1;
    wait_all(50, "t5b_drain");
    if (glog.size() >= base + 2) begin
      chk("t5b_first", glog[base], 32'd0);
      chk("t5b_second", glog[base + 1], 32'd1);
    end

`ifdef MEMARB_FIXED_PRIO_EN
    // Fixed priority: port 0 takes every contested grant
    src_en = 1'b0;
    base = glog.size();
    for (int i = 0; i < 4; i++) begin
      put(0, 1'b1, 8'(8'h60 + 4 * i), 32'h99990060 + 32'(4 * i));
      put(1, 1'b1, 8'(8'h70 + 4 * i), 32'haaaa0070 + 32'(4 * i));
    end
    src_en = 1'b1;
    wait_all(60, "t6_drain");
    for (int i = 0; i < 8 && base + i < glog.size(); i++)
      chk($sformatf("t6_grant%0d", i), glog[base + i], (i < 4) ? 32'd0 : 32'd1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
